// File: rtl/ibufds_activity_monitor_if.sv
// Bundle between the differential-buffer activity monitor and its surroundings.
// The clr signal exists only when ACTIVITY_MON_STICKY_EN is defined.
interface ibufds_activity_monitor_if #(
    parameter int CNT_W = 11
);
    logic             i;
    logic             ib;
    logic             o;
`ifdef ACTIVITY_MON_STICKY_EN
    logic             clr;
`endif
    logic [CNT_W-1:0] edge_cnt;
    logic             valid;
    logic             loss;
    logic             illegal;

    modport master (
        output i,
        output ib,
        output o,
`ifdef ACTIVITY_MON_STICKY_EN
        output clr,
`endif
        input  edge_cnt,
        input  valid,
        input  loss,
        input  illegal
    );

    modport slave (
        input  i,
        input  ib,
        input  o,
`ifdef ACTIVITY_MON_STICKY_EN
        input  clr,
`endif
        output edge_cnt,
        output valid,
        output loss,
        output illegal
    );
endinterface

// File: rtl/ibufds_activity_monitor.sv
// Windowed edge counter / loss-of-activity and illegal-pair monitor for a differential input buffer.
// Define ACTIVITY_MON_STICKY_EN to make LOSS/ILLEGAL sticky and add the clr input.
module ibufds_activity_monitor #(
    parameter int WINDOW      = 1024,
    parameter int CNT_W       = 11,
    parameter int MIN_EDGES   = 8,
    parameter int ILLEGAL_LIM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    ibufds_activity_monitor_if.slave    mon
);

    typedef enum logic [0:0] {
        ST_SETTLE  = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam int              WC_W        = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int              RC_W        = $clog2(ILLEGAL_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [WC_W-1:0]  WC_LAST    = WC_W'(WINDOW - 1);
    localparam logic [WC_W-1:0]  WC_ZERO    = {WC_W{1'b0}};
    localparam logic [RC_W-1:0]  RC_LIM     = RC_W'(ILLEGAL_LIM);
    localparam logic [RC_W-1:0]  RC_ZERO    = {RC_W{1'b0}};
    localparam logic [1:0]       SETTLE_LAST = 2'd2;

    // Saturating increment of the edge counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            cnt_sat_inc = v + CNT_W'(1);
        end else begin
            cnt_sat_inc = v;
        end
    endfunction

    // Saturating increment of the equal-pair run counter.
    function automatic logic [RC_W-1:0] rc_sat_inc(input logic [RC_W-1:0] v);
        if (v != RC_LIM) begin
            rc_sat_inc = v + RC_W'(1);
        end else begin
            rc_sat_inc = v;
        end
    endfunction

    logic [1:0]       i_sync_r;
    logic [1:0]       ib_sync_r;
    logic [2:0]       o_sync_r;
    state_t           state_r,    state_nxt_s;
    logic [1:0]       settle_r,   settle_nxt_s;
    logic [WC_W-1:0]  wc_r,       wc_nxt_s;
    logic [CNT_W-1:0] ec_r,       ec_nxt_s;
    logic [RC_W-1:0]  rc_r,       rc_nxt_s;
    logic [CNT_W-1:0] edge_cnt_r, edge_cnt_nxt_s;
    logic             valid_r,    valid_nxt_s;
    logic             loss_r,     loss_nxt_s;
    logic             illegal_r,  illegal_nxt_s;
    logic             measure_s;
    logic             win_end_s;
    logic [CNT_W-1:0] win_val_s;
    logic             loss_set_s;
    logic             illegal_set_s;
    logic             edge_s;
    logic             pair_eq_s;

    assign edge_s    = o_sync_r[1] & ~o_sync_r[2];
    assign pair_eq_s = i_sync_r[1] ~^ ib_sync_r[1];

    // Synchronizers for the asynchronous pad pair and buffer output.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_sync_r  <= 2'b00;
            ib_sync_r <= 2'b00;
            o_sync_r  <= 3'b000;
        end else begin
            i_sync_r  <= {i_sync_r[0], mon.i};
            ib_sync_r <= {ib_sync_r[0], mon.ib};
            o_sync_r  <= {o_sync_r[1:0], mon.o};
        end
    end

    // Settle/measure sequencing: wait for the synchronizers to fill before counting.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        case (state_r)
            ST_SETTLE: begin
                if (settle_r == SETTLE_LAST) begin
                    state_nxt_s  = ST_MEASURE;
                    settle_nxt_s = 2'd0;
                end else begin
                    settle_nxt_s = settle_r + 2'd1;
                end
            end
            ST_MEASURE: begin
                state_nxt_s = ST_MEASURE;
            end
            default: begin
                state_nxt_s  = ST_SETTLE;
                settle_nxt_s = 2'd0;
            end
        endcase
    end

    // Window counting, edge accumulation and flag evaluation.
    always_comb begin
        measure_s      = (state_r == ST_MEASURE);
        win_end_s      = measure_s && (wc_r == WC_LAST);
        win_val_s      = cnt_sat_inc(ec_r, edge_s);
        wc_nxt_s       = wc_r;
        ec_nxt_s       = ec_r;
        rc_nxt_s       = rc_r;
        edge_cnt_nxt_s = edge_cnt_r;
        valid_nxt_s    = 1'b0;
        if (measure_s) begin
            // The closing cycle's edge goes into the reported value; the next window starts from zero.
            if (win_end_s) begin
                wc_nxt_s       = WC_ZERO;
                ec_nxt_s       = CNT_ZERO;
                edge_cnt_nxt_s = win_val_s;
                valid_nxt_s    = 1'b1;
            end else begin
                wc_nxt_s = wc_r + WC_W'(1);
                ec_nxt_s = win_val_s;
            end
            if (pair_eq_s) begin
                rc_nxt_s = rc_sat_inc(rc_r);
            end else begin
                rc_nxt_s = RC_ZERO;
            end
        end else begin
            rc_nxt_s = rc_r;
        end
        loss_set_s    = win_end_s && (int'(win_val_s) < MIN_EDGES);
        illegal_set_s = measure_s && pair_eq_s && (rc_nxt_s == RC_LIM);
`ifdef ACTIVITY_MON_STICKY_EN
        // Setting beats a simultaneous clear.
        if (loss_set_s) begin
            loss_nxt_s = 1'b1;
        end else if (mon.clr) begin
            loss_nxt_s = 1'b0;
        end else begin
            loss_nxt_s = loss_r;
        end
        if (illegal_set_s) begin
            illegal_nxt_s = 1'b1;
        end else if (mon.clr) begin
            illegal_nxt_s = 1'b0;
        end else begin
            illegal_nxt_s = illegal_r;
        end
`else
        if (win_end_s) begin
            loss_nxt_s = loss_set_s;
        end else begin
            loss_nxt_s = loss_r;
        end
        if (measure_s) begin
            illegal_nxt_s = illegal_set_s;
        end else begin
            illegal_nxt_s = illegal_r;
        end
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_SETTLE;
            settle_r   <= 2'd0;
            wc_r       <= WC_ZERO;
            ec_r       <= CNT_ZERO;
            rc_r       <= RC_ZERO;
            edge_cnt_r <= CNT_ZERO;
            valid_r    <= 1'b0;
            loss_r     <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            settle_r   <= settle_nxt_s;
            wc_r       <= wc_nxt_s;
            ec_r       <= ec_nxt_s;
            rc_r       <= rc_nxt_s;
            edge_cnt_r <= edge_cnt_nxt_s;
            valid_r    <= valid_nxt_s;
            loss_r     <= loss_nxt_s;
            illegal_r  <= illegal_nxt_s;
        end
    end

    assign mon.edge_cnt = edge_cnt_r;
    assign mon.valid    = valid_r;
    assign mon.loss     = loss_r;
    assign mon.illegal  = illegal_r;

endmodule
